// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: instruction-memory req/ack bus, execute redirect and decode handshake.
// master = fetch stage side, slave = environment (memory, execute, decode).
interface fetch_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time and
// buffers {pc, instr} pairs in a small FIFO drained by decode; redirects flush it.
module fetch_stage #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CW    = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ack;
    logic              pop;
    logic              push;
    logic              flush;
    logic              issue_ok;
    logic              room_after_push;
    logic [XLEN-1:0]   redir_tgt;
    logic [XLEN-1:0]   addr_inc;
    entry_t            head;

    // Acks are only meaningful while a request is outstanding.
    assign ack       = bus.imem_ack & (state_q != S_IDLE);
    assign pop       = (count_q != '0) & bus.id_ready & ~bus.redirect_valid;
    assign redir_tgt = bus.redirect_pc & ~XLEN'(3);
    assign addr_inc  = addr_q + XLEN'(4);

    // Space checks account for a same-cycle pop so the FIFO never overflows.
    assign issue_ok        = ({1'b0, count_q} - CW'(pop)) < CW'(DEPTH);
    assign room_after_push = ({1'b0, count_q} + CW'(1) - CW'(pop)) < CW'(DEPTH);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.redirect_valid || issue_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    state_d = ack ? S_WAIT : S_DROP;
                end else if (ack && !room_after_push) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (ack) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state datapath control: fetch PC, request address, push/flush
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = bus.redirect_valid;
        case (state_q)
            S_IDLE: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                    addr_d     = redir_tgt;
                end else if (issue_ok) begin
                    addr_d = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                    if (ack) begin
                        addr_d = redir_tgt;
                    end
                end else if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_inc;
                    if (room_after_push) begin
                        addr_d = addr_inc;
                    end
                end
            end
            S_DROP: begin
                // The stale response is dropped; re-issue from the latest fetch PC.
                if (bus.redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                end
                if (ack) begin
                    addr_d = bus.redirect_valid ? redir_tgt : fetch_pc_q;
                end
            end
            default: begin
                fetch_pc_d = fetch_pc_q;
                addr_d     = addr_q;
            end
        endcase
    end

    // FIFO bookkeeping
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q].pc    = addr_q;
                mem_d[wr_ptr_q].instr = bus.imem_rdata;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            mem_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Outputs: request from state only; head view is combinational from the FIFO.
    assign head          = mem_q[rd_ptr_q];
    assign bus.imem_req  = (state_q != S_IDLE);
    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = (count_q != '0);
    assign bus.if_pc     = bus.if_valid ? head.pc : '0;
    assign bus.if_instr  = bus.if_valid ? head.instr : NOP;

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        push |-> (count_q < CNT_W'(DEPTH)));

    a_addr_stable : assert property (@(posedge clk) disable iff (!reset)
        (bus.imem_req && !ack) |=> $stable(bus.imem_addr));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based reference model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_fetch_stage;

    localparam int unsigned XLEN  = 64;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic rdy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_busy;
    bit          m_discard;
    logic [63:0] m_addr;
    logic [63:0] m_pc;
    ent_t        q[$];

    fetch_stage_if #(.XLEN(XLEN)) bus ();

    fetch_stage #(.XLEN(XLEN), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy    = 1'b0;
        m_discard = 1'b0;
        m_addr    = 64'h0;
        m_pc      = 64'h0;
        q.delete();
    endfunction

    // One clock of the spec's fetch rules, expressed as request/discard flags and a queue.
    function automatic void model_step(input bit ack_i, input logic [31:0] rd_i,
                                       input bit redir_i, input logic [63:0] tgt_i, input bit rdy_i);
        bit          a;
        bit          p;
        logic [63:0] t;
        ent_t        e;
        a = m_busy && ack_i;
        p = (q.size() != 0) && rdy_i && !redir_i;
        t = {tgt_i[63:2], 2'b00};
        if (redir_i) begin
            q.delete();
            m_pc = t;
            if (!m_busy || a) begin
                m_busy    = 1'b1;
                m_addr    = t;
                m_discard = 1'b0;
            end else begin
                m_discard = 1'b1;
            end
        end else begin
            if (p) void'(q.pop_front());
            if (a) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                    m_addr    = m_pc;
                end else begin
                    e.pc    = m_addr;
                    e.instr = rd_i;
                    q.push_back(e);
                    m_pc = m_addr + 64'd4;
                    if (q.size() < DEPTH) m_addr = m_pc;
                    else m_busy = 1'b0;
                end
            end else if (!m_busy && q.size() < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_pc;
            end
        end
    endfunction

    function automatic void check_model();
        chk("req",   64'(bus.imem_req), 64'(m_busy));
        chk("addr",  bus.imem_addr, m_addr);
        chk("valid", 64'(bus.if_valid), 64'(q.size() != 0));
        chk("pc",    bus.if_pc, (q.size() != 0) ? q[0].pc : 64'h0);
        chk("instr", 64'(bus.if_instr), 64'((q.size() != 0) ? q[0].instr : NOP));
    endfunction

    // Apply inputs at a falling edge, advance the model, then check after the next falling edge.
    task automatic step_raw(input bit ack_i, input logic [31:0] rd_i,
                            input bit redir_i, input logic [63:0] tgt_i);
        bus.imem_ack       = ack_i;
        bus.imem_rdata     = rd_i;
        bus.redirect_valid = redir_i;
        bus.redirect_pc    = tgt_i;
        bus.id_ready       = rdy;
        if (reset) model_step(ack_i, rd_i, redir_i, tgt_i, rdy);
        @(negedge clk);
        check_model();
    endtask

    // Zero-latency memory: ack every cycle a request is up.
    task automatic step_mem();
        if (bus.imem_req) step_raw(1'b1, memword(bus.imem_addr), 1'b0, 64'h0);
        else step_raw(1'b0, 32'h0, 1'b0, 64'h0);
    endtask

    initial begin
        reset              = 1'b0;
        rdy                = 1'b1;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.id_ready       = 1'b1;
        model_reset();

        @(negedge clk);
        check_model();
        chk("rst_req",   64'(bus.imem_req), 64'h0);
        chk("rst_addr",  bus.imem_addr, 64'h0);
        chk("rst_valid", 64'(bus.if_valid), 64'h0);
        chk("rst_instr", 64'(bus.if_instr), 64'h13);

        // Streaming with acks every cycle
        @(negedge clk);
        reset = 1'b1;
        step_mem();
        chk("first_req",  64'(bus.imem_req), 64'h1);
        chk("first_addr", bus.imem_addr, 64'h0);
        for (int k = 1; k <= 3; k++) begin
            step_mem();
            chk("stream_addr",  bus.imem_addr, 64'(4 * k));
            chk("stream_pc",    bus.if_pc, 64'(4 * (k - 1)));
            chk("stream_valid", 64'(bus.if_valid), 64'h1);
        end

        // Back-pressure: FIFO fills, request drops, resumes without gap
        rdy = 1'b0;
        step_mem();
        chk("bp_req", 64'(bus.imem_req), 64'h0);
        chk("bp_pc",  bus.if_pc, 64'h8);
        step_mem();
        chk("bp_hold_req", 64'(bus.imem_req), 64'h0);
        chk("bp_hold_pc",  bus.if_pc, 64'h8);
        rdy = 1'b1;
        step_mem();
        chk("resume_addr", bus.imem_addr, 64'h10);
        chk("resume_pc",   bus.if_pc, 64'hC);
        step_mem();
        chk("resume_pc2",  bus.if_pc, 64'h10);

        // Slow memory with redirect while waiting: late data must be dropped
        step_raw(1'b0, 32'h0, 1'b0, 64'h0);
        step_raw(1'b0, 32'h0, 1'b1, 64'h100);
        chk("drop_addr",  bus.imem_addr, 64'h14);
        chk("drop_valid", 64'(bus.if_valid), 64'h0);
        step_raw(1'b0, 32'h0, 1'b0, 64'h0);
        step_raw(1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0);
        chk("drop_reissue", bus.imem_addr, 64'h100);
        chk("drop_novalid", 64'(bus.if_valid), 64'h0);
        step_mem();
        chk("post_drop_pc",    bus.if_pc, 64'h100);
        chk("post_drop_instr", 64'(bus.if_instr), 64'hC0DE_0100);

        // Redirect with same-cycle ack, unaligned target
        step_raw(1'b1, 32'h1234_5678, 1'b1, 64'h203);
        chk("redir_addr",  bus.imem_addr, 64'h200);
        chk("redir_valid", 64'(bus.if_valid), 64'h0);
        chk("redir_instr", 64'(bus.if_instr), 64'h13);
        chk("redir_pc",    bus.if_pc, 64'h0);

        // PC wrap at the top of the address space
        step_raw(1'b1, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step_mem();
        chk("wrap_pc0",   bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr1", bus.imem_addr, 64'h0);
        step_mem();
        chk("wrap_pc1",    bus.if_pc, 64'h0);
        chk("wrap_instr1", 64'(bus.if_instr), 64'hC0DE_0000);

        // Reset mid-transaction with an entry queued and a request pending
        rdy = 1'b0;
        step_raw(1'b0, 32'h0, 1'b0, 64'h0);
        chk("pre_rst_valid", 64'(bus.if_valid), 64'h1);
        chk("pre_rst_req",   64'(bus.imem_req), 64'h1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_req",   64'(bus.imem_req), 64'h0);
        chk("mid_rst_addr",  bus.imem_addr, 64'h0);
        chk("mid_rst_valid", 64'(bus.if_valid), 64'h0);
        chk("mid_rst_instr", 64'(bus.if_instr), 64'h13);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check_model();
        reset = 1'b1;
        step_raw(1'b1, 32'hBAD0_BAD0, 1'b0, 64'h0);
        chk("rel_req",   64'(bus.imem_req), 64'h1);
        chk("rel_addr",  bus.imem_addr, 64'h0);
        chk("rel_valid", 64'(bus.if_valid), 64'h0);
        rdy = 1'b1;
        step_mem();
        chk("rel_pc",    bus.if_pc, 64'h0);
        chk("rel_instr", 64'(bus.if_instr), 64'hC0DE_0000);
        for (int k = 0; k < 4; k++) step_mem();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
